sort_stream_engine: RTL and testbench

Streaming, parametrised successor to the 8-input combinational character/weight sorter. Accepts up to N_ENTRY (character, weight) pairs serially over a valid/ready handshake. Sorts them on the fly by registered insertion. Streams them back out in rank order with backpressure and a last marker. Sits between the frequency-count stage and the Huffman-tree/encoding stage. Supports runtime descending/ascending mode and variable group length.

---
 rtl/sort_pkg.sv | 34 +++
 rtl/sort_stream_engine_if.sv | 32 +++
 rtl/sort_insert_cell.sv | 26 ++
 rtl/sort_stream_engine.sv | 130 +++++++++++++
 tb/tb_sort_stream_engine.sv | 277 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/sort_pkg.sv
// Shared state encoding, slot layout and rank rule for the streaming sorter.
// Slot fields are sized at a ceiling; narrower configurations zero-extend into them.
package sort_pkg;

  localparam int DEF_N_ENTRY  = 8;
  localparam int DEF_CHAR_W   = 4;
  localparam int DEF_WEIGHT_W = 5;
  localparam int CHAR_W_MAX   = 8;
  localparam int WEIGHT_W_MAX = 16;

  typedef enum logic [1:0] {
    S_IDLE,
    S_LOAD,
    S_DRAIN
  } state_t;

  typedef struct packed {
    logic                    valid;
    logic [CHAR_W_MAX-1:0]   ch;
    logic [WEIGHT_W_MAX-1:0] weight;
  } slot_t;

  // True when a must sit strictly ahead of b; equal keys return 0 so earlier arrivals stay first.
  function automatic logic ranks_before(input slot_t a, input slot_t b, input logic mode);
    logic [WEIGHT_W_MAX+CHAR_W_MAX-1:0] ka;
    logic [WEIGHT_W_MAX+CHAR_W_MAX-1:0] kb;
    if (!a.valid) return 1'b0;
    if (!b.valid) return 1'b1;
    ka = {a.weight, a.ch};
    kb = {b.weight, b.ch};
    return mode ? (ka < kb) : (ka > kb);
  endfunction

endpackage

// File: rtl/sort_stream_engine_if.sv
// Input and output stream bundle of the sorter; master is the upstream/downstream
// environment, slave is the engine.
interface sort_stream_engine_if #(
  parameter int CHAR_W   = sort_pkg::DEF_CHAR_W,
  parameter int WEIGHT_W = sort_pkg::DEF_WEIGHT_W,
  parameter int CNT_W    = $clog2(sort_pkg::DEF_N_ENTRY + 1)
);

  logic                in_valid;
  logic                in_ready;
  logic [CHAR_W-1:0]   in_char;
  logic [WEIGHT_W-1:0] in_weight;
  logic                in_last;
  logic                in_mode;
  logic                out_valid;
  logic                out_ready;
  logic [CHAR_W-1:0]   out_char;
  logic [WEIGHT_W-1:0] out_weight;
  logic                out_last;
  logic [CNT_W-1:0]    out_count;

  modport master (
    output in_valid, in_char, in_weight, in_last, in_mode, out_ready,
    input  in_ready, out_valid, out_char, out_weight, out_last, out_count
  );

  modport slave (
    input  in_valid, in_char, in_weight, in_last, in_mode, out_ready,
    output in_ready, out_valid, out_char, out_weight, out_last, out_count
  );

endinterface

// File: rtl/sort_insert_cell.sv
// One slot of the insertion array: keeps its entry, takes the new beat, or takes
// the entry of the slot above when the new beat lands higher up.
module sort_insert_cell
  import sort_pkg::*;
(
  input  slot_t i_new,
  input  slot_t i_prev,
  input  slot_t i_own,
  input  logic  i_mode,
  input  logic  i_prev_take,
  output logic  o_take,
  output slot_t o_next
);

  // The take chain is monotonic because the array is sorted with empties at the tail.
  always_comb begin
    o_take = ranks_before(i_new, i_own, i_mode);
    o_next = i_own;
    if (i_prev_take) begin
      o_next = i_prev;
    end else if (o_take) begin
      o_next = i_new;
    end
  end

endmodule

// File: rtl/sort_stream_engine.sv
// Streaming insertion sorter: loads up to N_ENTRY (char, weight) beats, keeps them
// ranked on every insert, then drains them in rank order with backpressure.
module sort_stream_engine
  import sort_pkg::*;
#(
  parameter int N_ENTRY  = DEF_N_ENTRY,
  parameter int CHAR_W   = DEF_CHAR_W,
  parameter int WEIGHT_W = DEF_WEIGHT_W,
  parameter int CNT_W    = $clog2(N_ENTRY + 1)
) (
  input logic clk,
  input logic rst_n,
  sort_stream_engine_if.slave bus
);

  state_t           r_state;
  state_t           w_next_state;
  slot_t            r_slots [N_ENTRY];
  logic [CNT_W-1:0] r_count;
  logic [CNT_W-1:0] r_total;
  logic             r_mode;

  slot_t            w_new;
  slot_t            w_empty;
  slot_t            w_prev [N_ENTRY];
  slot_t            w_ins  [N_ENTRY];
  logic [N_ENTRY:0] w_chain;
  logic             w_ins_mode;
  logic             w_in_ready;
  logic             w_in_fire;
  logic             w_in_done;
  logic             w_out_valid;
  logic             w_out_last;
  logic             w_out_fire;

  assign w_empty    = '0;
  assign w_chain[0] = 1'b0;
  assign w_ins_mode = (r_state == S_IDLE) ? bus.in_mode : r_mode;
  assign w_in_fire  = bus.in_valid && w_in_ready;
  assign w_out_fire = w_out_valid && bus.out_ready;

  always_comb begin
    w_new        = '0;
    w_new.valid  = 1'b1;
    w_new.ch     = CHAR_W_MAX'(bus.in_char);
    w_new.weight = WEIGHT_W_MAX'(bus.in_weight);
  end

  for (genvar g = 0; g < N_ENTRY; g++) begin : g_cell
    if (g == 0) begin : g_head
      assign w_prev[g] = w_empty;
    end else begin : g_body
      assign w_prev[g] = r_slots[g-1];
    end

    sort_insert_cell u_cell (
      .i_new       (w_new),
      .i_prev      (w_prev[g]),
      .i_own       (r_slots[g]),
      .i_mode      (w_ins_mode),
      .i_prev_take (w_chain[g]),
      .o_take      (w_chain[g+1]),
      .o_next      (w_ins[g])
    );
  end

  always_comb begin
    w_next_state = r_state;
    w_in_done    = 1'b0;
    w_in_ready   = rst_n && (r_state != S_DRAIN);
    w_out_valid  = (r_state == S_DRAIN);
    w_out_last   = w_out_valid && (r_count == CNT_W'(1));
    case (r_state)
      S_IDLE, S_LOAD: begin
        if (w_in_fire) begin
          w_in_done    = bus.in_last || (r_count == CNT_W'(N_ENTRY - 1));
          w_next_state = w_in_done ? S_DRAIN : S_LOAD;
        end
      end
      S_DRAIN: begin
        if (w_out_fire && w_out_last) begin
          w_next_state = S_IDLE;
        end
      end
      default: w_next_state = S_IDLE;
    endcase
  end

  always_comb begin
    bus.in_ready   = w_in_ready;
    bus.out_valid  = w_out_valid;
    bus.out_last   = w_out_last;
    bus.out_char   = w_out_valid ? CHAR_W'(r_slots[0].ch) : '0;
    bus.out_weight = w_out_valid ? WEIGHT_W'(r_slots[0].weight) : '0;
    bus.out_count  = w_out_valid ? r_total : '0;
  end

  // The top of the take chain doubles as a room flag, so a full table is never overwritten.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_mode  <= 1'b0;
      r_count <= '0;
      r_total <= '0;
      for (int i = 0; i < N_ENTRY; i++) r_slots[i] <= '0;
    end else begin
      r_state <= w_next_state;
      if (w_in_fire) begin
        if (w_chain[N_ENTRY]) begin
          for (int i = 0; i < N_ENTRY; i++) r_slots[i] <= w_ins[i];
        end
        r_count <= r_count + CNT_W'(1);
        r_total <= r_count + CNT_W'(1);
        if (r_state == S_IDLE) r_mode <= bus.in_mode;
      end else if (w_out_fire) begin
        if (w_out_last) begin
          r_mode  <= 1'b0;
          r_count <= '0;
          r_total <= '0;
          for (int i = 0; i < N_ENTRY; i++) r_slots[i] <= '0;
        end else begin
          r_count <= r_count - CNT_W'(1);
          for (int i = 0; i < N_ENTRY - 1; i++) r_slots[i] <= r_slots[i+1];
          r_slots[N_ENTRY-1] <= '0;
        end
      end
    end
  end

endmodule

// File: tb/tb_sort_stream_engine.sv
// Bench for sort_stream_engine: directed groups from the plan plus random groups,
// each compared against a rank-counting reference sort.
module tb_sort_stream_engine;

  localparam int N  = 8;
  localparam int CW = 4;
  localparam int WW = 5;
  localparam int NW = 4;

  logic clk = 1'b0;
  logic rst_n;

  always #5 clk = ~clk;

  sort_stream_engine_if #(.CHAR_W(CW), .WEIGHT_W(WW), .CNT_W(NW)) bus ();

  sort_stream_engine #(
    .N_ENTRY  (N),
    .CHAR_W   (CW),
    .WEIGHT_W (WW),
    .CNT_W    (NW)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int   nVec  = 0;
  int   nFail = 0;
  int   gChar     [N];
  int   gWeight   [N];
  int   expChar   [N];
  int   expWeight [N];
  int   gLen;
  logic gMode;

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nVec++;
    assert (obs === exp) else begin
      nFail++;
      $error("[TB] FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Position of each entry = entries that rank strictly ahead plus equal keys that arrived earlier.
  function automatic void modelSort();
    for (int j = 0; j < gLen; j++) begin
      int keyJ;
      int pos;
      keyJ = gWeight[j] * 16 + gChar[j];
      pos  = 0;
      for (int k = 0; k < gLen; k++) begin
        int keyK;
        keyK = gWeight[k] * 16 + gChar[k];
        if (gMode ? (keyK < keyJ) : (keyK > keyJ)) pos++;
        else if (keyK == keyJ && k < j) pos++;
      end
      expChar[pos]   = gChar[j];
      expWeight[pos] = gWeight[j];
    end
  endfunction

  task automatic applyStimulus(input logic useLast);
    for (int i = 0; i < gLen; i++) begin
      if (i > 0 && $urandom_range(0, 3) == 0) begin
        bus.in_valid = 1'b0;
        bus.in_last  = 1'($urandom);
        bus.in_char  = CW'($urandom);
        @(negedge clk);
      end
      bus.in_valid  = 1'b1;
      bus.in_char   = CW'(gChar[i]);
      bus.in_weight = WW'(gWeight[i]);
      bus.in_last   = useLast && (i == gLen - 1);
      bus.in_mode   = (i == 0) ? gMode : 1'($urandom);
      checkOutput("in_ready_load", bus.in_ready, 1);
      @(negedge clk);
    end
    bus.in_valid = 1'b0;
    bus.in_last  = 1'b0;
  endtask

  task automatic drainCheck(input int pat, input int stopAfter);
    int   idx;
    int   cyc;
    logic rdy;
    idx = 0;
    cyc = 0;
    while (idx < stopAfter && cyc < 200) begin
      checkOutput("out_valid", bus.out_valid, 1);
      checkOutput("out_char", bus.out_char, expChar[idx]);
      checkOutput("out_weight", bus.out_weight, expWeight[idx]);
      checkOutput("out_last", bus.out_last, (idx == gLen - 1));
      checkOutput("out_count", bus.out_count, gLen);
      checkOutput("in_ready_drain", bus.in_ready, 0);
      case (pat)
        0:       rdy = 1'b1;
        1:       rdy = 1'($urandom);
        default: rdy = (cyc < 2) ? 1'b1 : (cyc < 7) ? 1'b0 : ((cyc % 2) == 1);
      endcase
      bus.out_ready = rdy;
      @(negedge clk);
      if (rdy) idx++;
      cyc++;
    end
    bus.out_ready = 1'b0;
    checkOutput("drain_beats", idx, stopAfter);
  endtask

  task automatic checkIdle(input string tag);
    checkOutput({tag, "_out_valid"}, bus.out_valid, 0);
    checkOutput({tag, "_out_char"}, bus.out_char, 0);
    checkOutput({tag, "_out_weight"}, bus.out_weight, 0);
    checkOutput({tag, "_out_last"}, bus.out_last, 0);
    checkOutput({tag, "_out_count"}, bus.out_count, 0);
    checkOutput({tag, "_in_ready"}, bus.in_ready, 1);
  endtask

  task automatic resetPulse();
    rst_n = 1'b0;
    #1;
    checkOutput("rst_in_ready_low", bus.in_ready, 0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    checkIdle("after_rst");
  endtask

  initial begin
    #300000;
    $display("[TB] FAIL watchdog: time limit reached before summary");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    rst_n         = 1'b0;
    bus.in_valid  = 1'b0;
    bus.in_char   = '0;
    bus.in_weight = '0;
    bus.in_last   = 1'b0;
    bus.in_mode   = 1'b0;
    bus.out_ready = 1'b0;
    repeat (2) @(negedge clk);
    checkOutput("reset_in_ready", bus.in_ready, 0);
    checkOutput("reset_out_valid", bus.out_valid, 0);
    checkOutput("reset_out_count", bus.out_count, 0);
    rst_n = 1'b1;
    #1;
    checkIdle("reset");

    $display("[TB] descending 8-beat group");
    gLen      = 8;
    gMode     = 1'b0;
    gChar     = '{0, 1, 2, 3, 4, 5, 6, 7};
    gWeight   = '{3, 7, 3, 0, 31, 7, 1, 3};
    expChar   = '{4, 5, 1, 7, 2, 0, 6, 3};
    expWeight = '{31, 7, 7, 3, 3, 3, 1, 0};
    applyStimulus(1'b1);
    drainCheck(0, 8);
    checkIdle("desc");

    $display("[TB] ascending 8-beat group");
    gMode     = 1'b1;
    expChar   = '{3, 6, 0, 2, 7, 1, 5, 4};
    expWeight = '{0, 1, 3, 3, 3, 7, 7, 31};
    applyStimulus(1'b1);
    drainCheck(1, 8);
    checkIdle("asc");

    $display("[TB] short group with ties");
    gLen       = 3;
    gMode      = 1'b0;
    gChar[0]   = 10; gWeight[0] = 5;
    gChar[1]   = 11; gWeight[1] = 5;
    gChar[2]   = 9;  gWeight[2] = 2;
    modelSort();
    applyStimulus(1'b1);
    drainCheck(0, 3);
    checkIdle("ties");

    $display("[TB] duplicate keys");
    gLen       = 2;
    gChar[0]   = 3; gWeight[0] = 4;
    gChar[1]   = 3; gWeight[1] = 4;
    modelSort();
    applyStimulus(1'b1);
    drainCheck(1, 2);
    checkIdle("dup");

    $display("[TB] single-beat group");
    gLen       = 1;
    gMode      = 1'b1;
    gChar[0]   = 7; gWeight[0] = 9;
    modelSort();
    applyStimulus(1'b1);
    drainCheck(0, 1);
    checkIdle("single");

    $display("[TB] backpressure during drain");
    gLen      = 8;
    gMode     = 1'b0;
    gChar     = '{0, 1, 2, 3, 4, 5, 6, 7};
    gWeight   = '{3, 7, 3, 0, 31, 7, 1, 3};
    expChar   = '{4, 5, 1, 7, 2, 0, 6, 3};
    expWeight = '{31, 7, 7, 3, 3, 3, 1, 0};
    applyStimulus(1'b1);
    drainCheck(2, 8);
    checkIdle("bp");

    $display("[TB] full group without in_last, ninth beat held");
    gLen  = 8;
    gMode = 1'b1;
    for (int i = 0; i < N; i++) begin
      gChar[i]   = int'($urandom_range(0, 15));
      gWeight[i] = int'($urandom_range(0, 3));
    end
    modelSort();
    applyStimulus(1'b0);
    bus.in_valid  = 1'b1;
    bus.in_char   = 4'd5;
    bus.in_weight = 5'd2;
    bus.in_last   = 1'b0;
    bus.in_mode   = 1'b0;
    drainCheck(0, 8);
    checkIdle("nolast");
    gLen       = 2;
    gMode      = 1'b0;
    gChar[0]   = 5; gWeight[0] = 2;
    gChar[1]   = 6; gWeight[1] = 2;
    modelSort();
    applyStimulus(1'b1);
    drainCheck(0, 2);
    checkIdle("ninth");

    $display("[TB] reset mid-load and mid-drain");
    gLen  = 4;
    gMode = 1'b0;
    for (int i = 0; i < 4; i++) begin
      gChar[i]   = i + 8;
      gWeight[i] = 20 - i;
    end
    applyStimulus(1'b0);
    resetPulse();
    gLen = 3;
    modelSort();
    applyStimulus(1'b1);
    drainCheck(0, 1);
    resetPulse();
    gLen       = 2;
    gMode      = 1'b0;
    gChar[0]   = 1; gWeight[0] = 9;
    gChar[1]   = 2; gWeight[1] = 1;
    modelSort();
    applyStimulus(1'b1);
    drainCheck(0, 2);
    checkIdle("post_rst");

    $display("[TB] random groups");
    for (int t = 0; t < 30; t++) begin
      gLen  = int'($urandom_range(1, N));
      gMode = 1'($urandom);
      for (int i = 0; i < N; i++) begin
        gChar[i]   = int'($urandom_range(0, 15));
        gWeight[i] = ($urandom_range(0, 1) == 1) ? int'($urandom_range(0, 31))
                                                 : int'($urandom_range(0, 2));
      end
      modelSort();
      applyStimulus((gLen < N) ? 1'b1 : 1'($urandom));
      drainCheck(int'($urandom_range(0, 2)), gLen);
      checkIdle("rand");
    end

    $display("== %0d vectors applied, %0d miscompares ==", nVec, nFail);
    $finish;
  end

endmodule
